pwm_controller: RTL and testbench
=================================

PWM_CONTROLLER -- requirements
Module: pwm_controller

Interface
REQ-001 The block SHALL have a single clock domain; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 A  input  2  register select: 0 CTRL, 1 PERIOD, 2 DUTY, 3 PRESC.
REQ-005 WD  input  32  write data.
REQ-006 WE  input  1  write strobe; one register written per asserted cycle.
REQ-007 RD  output  32  combinational readback of the register selected by A, zero-extended.
REQ-008 PWM  output  1  PWM waveform, shared by all outputs of the analog/digital output mux.
REQ-009 IRQ  output  1  period-end interrupt flag (PWM_PERIOD_IRQ_EN only; tied 0 otherwise).

Function
REQ-010 Live registers SHALL be: CTRL.EN (bit0), PERIOD[15:0], DUTY[15:0], PRESC[7:0]; write bits beyond a field's width SHALL be ignored.
REQ-011 Shadow registers PERIOD_SH, DUTY_SH, PRESC_SH SHALL drive the counters; live registers SHALL never drive them directly.
REQ-012 FSM states SHALL be IDLE and RUN; IDLE->RUN on the edge where CTRL.EN is written 1; RUN->IDLE on the edge where CTRL.EN is written 0.
REQ-013 On IDLE->RUN the block SHALL clear the prescaler counter PC and the period counter CNT and load all shadows from the live values written in that same edge or earlier.
REQ-014 In RUN, PC SHALL increment each clock; when PC==PRESC_SH, PC SHALL return to 0 and a tick SHALL occur.
REQ-015 On a tick CNT SHALL increment; on a tick with CNT==PERIOD_SH, CNT SHALL return to 0 (period end).
REQ-016 PWM SHALL equal (state==RUN) && (CNT < DUTY_SH), decoded from registered state only.
REQ-017 PWM period SHALL be (PERIOD_SH+1)*(PRESC_SH+1) clocks; high time SHALL be min(DUTY_SH, PERIOD_SH+1)*(PRESC_SH+1) clocks.
REQ-018 DUTY_SH==0 SHALL give constant low; DUTY_SH>PERIOD_SH SHALL give constant high; PERIOD_SH==0 SHALL be legal (1-tick period).
REQ-019 A write to PERIOD, DUTY or PRESC while in RUN SHALL set a PENDING flag; at the next period end all three shadows SHALL load from live values and PENDING SHALL clear in that edge.
REQ-020 A write to PERIOD/DUTY/PRESC coinciding with a period end SHALL be captured by that same shadow load, and PENDING SHALL end cleared.
REQ-021 Writes in IDLE SHALL update live registers only and SHALL NOT set PENDING.
REQ-022 RUN->IDLE SHALL clear PC, CNT and PENDING; PWM SHALL be low from the following cycle.
REQ-023 CTRL read SHALL return {29'b0, IRQ_FLAG, PENDING, EN}; other reads SHALL return live (not shadow) values.

Reset
REQ-024 rst SHALL force state IDLE, EN=0, PERIOD=16'hFFFF, DUTY=0, PRESC=0, all shadows equal to these, PC=0, CNT=0, PENDING=0, IRQ_FLAG=0.
REQ-025 After reset PWM=0, IRQ=0, RD reflects the reset values; rst SHALL take priority over a simultaneous WE.
REQ-026 rst asserted mid-period SHALL abort the period with no shadow load.

Configuration
REQ-027 Macro PWM_PERIOD_IRQ_EN: when defined, IRQ_FLAG SHALL set at every period end in RUN, IRQ SHALL equal IRQ_FLAG, and writing CTRL with bit1=1 SHALL clear it (set wins over clear in the same edge).
REQ-028 Without PWM_PERIOD_IRQ_EN, IRQ_FLAG logic SHALL be absent, IRQ SHALL be constant 0, and CTRL bit2 SHALL read 0.

Verification
REQ-029 PERIOD=9, DUTY=3, PRESC=0, EN=1 -> PWM high 3 clocks, low 7, repeating with period 10.
REQ-030 PERIOD=3, DUTY=2, PRESC=4 -> period 20 clocks, high 10 clocks.
REQ-031 Running PERIOD=9 DUTY=3; write DUTY=7 mid-period -> CTRL reads PENDING=1, current period stays 3/7, next period 7/3, PENDING=0 after load.
REQ-032 DUTY=0 -> PWM constant 0; DUTY=12 with PERIOD=9 -> PWM constant 1; PERIOD=0 DUTY=1 -> constant 1.
REQ-033 rst asserted during RUN with WE=1 -> next cycle PWM=0, CTRL reads 0, PERIOD reads 0x0000FFFF.
REQ-034 PWM_PERIOD_IRQ_EN defined, PERIOD=4 -> IRQ rises after first period end; CTRL write bit1=1 clears it; clear coinciding with period end leaves IRQ=1.

Source files
------------

// File: rtl/pwm_controller.sv
// -----------------------------------------------------------------------------
// pwm_controller
//
// Register-programmed PWM generator with shadowed configuration. Software
// writes the live PERIOD/DUTY/PRESC registers. The counters only ever see the
// shadow copies. Shadows are loaded when the block is enabled, and at a period
// end when a configuration write is pending. This keeps every emitted period
// internally consistent.
//
// Optional feature (macro PWM_PERIOD_IRQ_EN): a sticky period-end interrupt
// flag. Software clears it by writing CTRL with bit1 set. A set in the same
// edge wins over the clear. When the macro is undefined, IRQ is tied low and
// CTRL bit2 reads 0.
//
// Ports
//   clk  in   1   system clock, rising-edge active
//   rst  in   1   synchronous active-high reset (wins over WE)
//   A    in   2   register select: 0 CTRL, 1 PERIOD, 2 DUTY, 3 PRESC
//   WD   in   32  write data
//   WE   in   1   write strobe, one register per cycle
//   RD   out  32  combinational readback of the register selected by A
//   PWM  out  1   PWM waveform
//   IRQ  out  1   period-end interrupt flag (0 without PWM_PERIOD_IRQ_EN)
// -----------------------------------------------------------------------------
module pwm_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  A,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    output logic        PWM,
    output logic        IRQ
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_DUTY   = 2'd2;
    localparam logic [1:0] ADDR_PRESC  = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_r;
    logic        en_r;
    logic [15:0] period_r;
    logic [15:0] duty_r;
    logic [7:0]  presc_r;
    logic [15:0] period_sh_r;
    logic [15:0] duty_sh_r;
    logic [7:0]  presc_sh_r;
    logic [7:0]  pc_r;
    logic [15:0] cnt_r;
    logic        pending_r;

    logic [15:0] period_nxt_s;
    logic [15:0] duty_nxt_s;
    logic [7:0]  presc_nxt_s;
    logic        wr_ctrl_s;
    logic        wr_cfg_s;
    logic        start_s;
    logic        stop_s;
    logic        tick_s;
    logic        period_end_s;
    logic        irq_flag_s;

    // Only bits [15:0] of the write data reach any register.
    logic        unused_wd_s;
    assign unused_wd_s = ^WD[31:16];

    assign wr_ctrl_s    = WE && (A == ADDR_CTRL);
    assign wr_cfg_s     = WE && (A != ADDR_CTRL);
    assign start_s      = (state_r == ST_IDLE) && wr_ctrl_s && WD[0];
    assign stop_s       = (state_r == ST_RUN) && wr_ctrl_s && !WD[0];
    assign tick_s       = (state_r == ST_RUN) && (pc_r == presc_sh_r);
    assign period_end_s = tick_s && (cnt_r == period_sh_r);

    // Live register values as they will be after this edge. A shadow load in
    // the same edge as a config write then captures the newly written value.
    always_comb begin
        period_nxt_s = period_r;
        duty_nxt_s   = duty_r;
        presc_nxt_s  = presc_r;
        if (WE) begin
            case (A)
                ADDR_PERIOD: period_nxt_s = WD[15:0];
                ADDR_DUTY:   duty_nxt_s   = WD[15:0];
                ADDR_PRESC:  presc_nxt_s  = WD[7:0];
                default:     period_nxt_s = period_r;
            endcase
        end else begin
            period_nxt_s = period_r;
        end
    end

    // Control FSM, live and shadow registers, prescaler and period counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            en_r        <= 1'b0;
            period_r    <= 16'hFFFF;
            duty_r      <= 16'h0000;
            presc_r     <= 8'h00;
            period_sh_r <= 16'hFFFF;
            duty_sh_r   <= 16'h0000;
            presc_sh_r  <= 8'h00;
            pc_r        <= 8'h00;
            cnt_r       <= 16'h0000;
            pending_r   <= 1'b0;
        end else begin
            period_r <= period_nxt_s;
            duty_r   <= duty_nxt_s;
            presc_r  <= presc_nxt_s;
            if (wr_ctrl_s) begin
                en_r <= WD[0];
            end else begin
                en_r <= en_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r     <= ST_RUN;
                        pc_r        <= 8'h00;
                        cnt_r       <= 16'h0000;
                        period_sh_r <= period_nxt_s;
                        duty_sh_r   <= duty_nxt_s;
                        presc_sh_r  <= presc_nxt_s;
                        pending_r   <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop_s) begin
                        state_r   <= ST_IDLE;
                        pc_r      <= 8'h00;
                        cnt_r     <= 16'h0000;
                        pending_r <= 1'b0;
                    end else begin
                        if (tick_s) begin
                            pc_r <= 8'h00;
                            if (period_end_s) begin
                                cnt_r <= 16'h0000;
                            end else begin
                                cnt_r <= cnt_r + 16'd1;
                            end
                        end else begin
                            pc_r <= pc_r + 8'd1;
                        end

                        // A write landing on the period end is folded into
                        // the load, so PENDING never survives that edge.
                        if (period_end_s && (pending_r || wr_cfg_s)) begin
                            period_sh_r <= period_nxt_s;
                            duty_sh_r   <= duty_nxt_s;
                            presc_sh_r  <= presc_nxt_s;
                            pending_r   <= 1'b0;
                        end else if (wr_cfg_s) begin
                            pending_r <= 1'b1;
                        end else begin
                            pending_r <= pending_r;
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    pc_r      <= 8'h00;
                    cnt_r     <= 16'h0000;
                    pending_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef PWM_PERIOD_IRQ_EN
    logic irq_flag_r;

    // Sticky period-end flag. A set in the same edge wins over a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_flag_r <= 1'b0;
        end else if (period_end_s) begin
            irq_flag_r <= 1'b1;
        end else if (wr_ctrl_s && WD[1]) begin
            irq_flag_r <= 1'b0;
        end else begin
            irq_flag_r <= irq_flag_r;
        end
    end

    assign irq_flag_s = irq_flag_r;
`else
    assign irq_flag_s = 1'b0;
`endif

    assign IRQ = irq_flag_s;

    // The waveform is decoded from registered state only.
    assign PWM = (state_r == ST_RUN) && (cnt_r < duty_sh_r);

    // Readback returns live values. Shadows are not software-visible.
    always_comb begin
        RD = 32'h0000_0000;
        case (A)
            ADDR_CTRL:   RD = {29'd0, irq_flag_s, pending_r, en_r};
            ADDR_PERIOD: RD = {16'd0, period_r};
            ADDR_DUTY:   RD = {16'd0, duty_r};
            ADDR_PRESC:  RD = {24'd0, presc_r};
            default:     RD = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_pwm_controller.sv
// -----------------------------------------------------------------------------
// tb_pwm_controller
//
// Directed scenarios followed by randomized register traffic. The reference
// model tracks only the position inside the current PWM period. Expected PWM
// is "position < min(DUTY,PERIOD+1)*(PRESC+1)". The period length is
// (PERIOD+1)*(PRESC+1). Shadow reload, PENDING and IRQ rules are applied at
// period boundaries.
// -----------------------------------------------------------------------------
module tb_pwm_controller;

    logic        clk;
    logic        rst;
    logic [1:0]  A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;
    logic        PWM;
    logic        IRQ;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_p, m_d, m_s, m_en;
    int sh_p, sh_d, sh_s;
    int m_run, m_pend, m_irq, m_pos;

    pwm_controller dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .WD  (WD),
        .WE  (WE),
        .RD  (RD),
        .PWM (PWM),
        .IRQ (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int plen();
        return (sh_p + 1) * (sh_s + 1);
    endfunction

    function automatic int hlen();
        int dd;
        dd = (sh_d < sh_p + 1) ? sh_d : sh_p + 1;
        return dd * (sh_s + 1);
    endfunction

    function automatic logic exp_irq();
`ifdef PWM_PERIOD_IRQ_EN
        return logic'(m_irq != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] ra);
        case (ra)
            2'd0:    return {29'd0, exp_irq(), logic'(m_pend != 0), logic'(m_en != 0)};
            2'd1:    return 32'(m_p);
            2'd2:    return 32'(m_d);
            default: return 32'(m_s);
        endcase
    endfunction

    task automatic model_reset();
        m_p = 16'hFFFF; m_d = 0; m_s = 0; m_en = 0;
        sh_p = m_p; sh_d = m_d; sh_s = m_s;
        m_run = 0; m_pend = 0; m_irq = 0; m_pos = 0;
    endtask

    task automatic model_edge(input logic r, input logic we, input logic [1:0] a, input logic [31:0] wd);
        int  np, nd, ns;
        bit  ctl, cfg, pend_end;
        if (r) begin
            model_reset();
            return;
        end
        ctl = we && (a == 2'd0);
        cfg = we && (a != 2'd0);
        np = m_p; nd = m_d; ns = m_s;
        if (we && a == 2'd1) np = int'(wd[15:0]);
        if (we && a == 2'd2) nd = int'(wd[15:0]);
        if (we && a == 2'd3) ns = int'(wd[7:0]);
        pend_end = (m_run != 0) && (m_pos + 1 == plen());
        if (m_run != 0) begin
            if (ctl && !wd[0]) begin
                m_run = 0; m_pos = 0; m_pend = 0;
            end else begin
                m_pos++;
                if (pend_end) begin
                    m_pos = 0;
                    if (m_pend != 0 || cfg) begin
                        sh_p = np; sh_d = nd; sh_s = ns; m_pend = 0;
                    end
                end else if (cfg) begin
                    m_pend = 1;
                end
            end
        end else if (ctl && wd[0]) begin
            m_run = 1; m_pos = 0; m_pend = 0;
            sh_p = np; sh_d = nd; sh_s = ns;
        end
        if (pend_end) m_irq = 1;
        else if (ctl && wd[1]) m_irq = 0;
        if (ctl) m_en = int'(wd[0]);
        m_p = np; m_d = nd; m_s = ns;
    endtask

    // One clock: apply inputs, clock, update model, then read register ra and check.
    task automatic step(input logic r, input logic we, input logic [1:0] a,
                        input logic [31:0] wd, input logic [1:0] ra);
        rst = r; WE = we; A = a; WD = wd;
        @(posedge clk);
        model_edge(r, we, a, wd);
        #1;
        rst = 1'b0; WE = 1'b0; A = ra;
        #1;
        chk("pwm", {31'd0, PWM}, {31'd0, logic'(m_run != 0 && m_pos < hlen())});
        chk("irq", {31'd0, IRQ}, {31'd0, exp_irq()});
        chk("rd", RD, exp_rd(ra));
    endtask

    task automatic idle_count(input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b0, 2'd0, 32'd0, 2'(k));
            hi += int'(PWM);
        end
    endtask

    task automatic configure(input int p, input int d, input int s);
        step(1'b0, 1'b1, 2'd0, 32'h0, 2'd0);
        step(1'b0, 1'b1, 2'd1, 32'(p), 2'd1);
        step(1'b0, 1'b1, 2'd2, 32'(d), 2'd2);
        step(1'b0, 1'b1, 2'd3, 32'(s), 2'd3);
        step(1'b0, 1'b1, 2'd0, 32'h1, 2'd0);
    endtask

    initial begin
        int hi;
        logic        r, we;
        logic [1:0]  a;
        logic [31:0] wd;

        rst = 1'b1; WE = 1'b0; A = 2'd0; WD = 32'd0;
        model_reset();

        // reset state, reset wins over a simultaneous write
        step(1'b1, 1'b1, 2'd1, 32'h5, 2'd0);
        chk("rst_ctrl", RD, 32'h0);
        step(1'b0, 1'b0, 2'd0, 32'd0, 2'd1);
        chk("rst_period", RD, 32'h0000FFFF);

        // 10-clock period, 3 high
        configure(9, 3, 0);
        idle_count(20, hi);
        chk("p9d3_high", 32'(hi), 32'd6);

        // duty change mid-period becomes pending, applied at next period
        idle_count(4, hi);
        step(1'b0, 1'b1, 2'd2, 32'd7, 2'd0);
        chk("pending_set", RD, 32'h3);
        idle_count(14, hi);
        chk("new_duty_high", 32'(hi), 32'd7);
        step(1'b0, 1'b0, 2'd0, 32'd0, 2'd0);
        chk("pending_clr", RD, 32'h1);

        // prescaled: period 20, high 10
        configure(3, 2, 4);
        idle_count(20, hi);
        chk("presc_high", 32'(hi), 32'd10);

        // boundary duties
        configure(9, 0, 0);
        idle_count(12, hi);
        chk("duty0_low", 32'(hi), 32'd0);
        configure(9, 12, 0);
        idle_count(12, hi);
        chk("duty_over_high", 32'(hi), 32'd12);
        configure(0, 1, 0);
        idle_count(12, hi);
        chk("period0_high", 32'(hi), 32'd12);

        // reset during RUN with a write
        step(1'b1, 1'b1, 2'd0, 32'h1, 2'd0);
        chk("rst_run_pwm", {31'd0, PWM}, 32'd0);
        chk("rst_run_ctrl", RD, 32'h0);
        step(1'b0, 1'b0, 2'd0, 32'd0, 2'd1);
        chk("rst_run_period", RD, 32'h0000FFFF);

        // period-end interrupt, clear, and clear colliding with period end
        configure(4, 2, 0);
        idle_count(5, hi);
`ifdef PWM_PERIOD_IRQ_EN
        chk("irq_set", {31'd0, IRQ}, 32'd1);
`else
        chk("irq_absent", {31'd0, IRQ}, 32'd0);
`endif
        step(1'b0, 1'b1, 2'd0, 32'h3, 2'd0);
        chk("irq_clr", {31'd0, IRQ}, 32'd0);
        idle_count(3, hi);
        step(1'b0, 1'b1, 2'd0, 32'h3, 2'd0);
`ifdef PWM_PERIOD_IRQ_EN
        chk("irq_set_wins", {31'd0, IRQ}, 32'd1);
`else
        chk("irq_absent2", {31'd0, IRQ}, 32'd0);
`endif

        // randomized register traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            we = ($urandom_range(0, 3) == 0);
            a  = 2'($urandom_range(0, 3));
            case (a)
                2'd0:    wd = ($urandom & 32'hFFFF_FFFC)
                              | {30'd0, 1'($urandom_range(0, 1)), logic'($urandom_range(0, 4) != 0)};
                2'd1:    wd = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
                2'd2:    wd = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 15));
                default: wd = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 3));
            endcase
            step(r, we, a, wd, 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
